// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Main control FSM for the multi-cycle MIPS CPU. It steps the
//                shared datapath (one memory port, one ALU and the
//                PC/IR/A/B/ALUOut/MDR registers) through 3-5 cycles per
//                instruction. Every datapath enable and mux select is a Moore
//                function of the current state. The exceptions are
//                illegal_op and instr_done in DECODE, which also depend on
//                the opcode. ALU funct decoding stays in the ALU-control
//                block, which this FSM steers through ALUOp.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1  clock, rising edge
//    rst          in   1  reset, asynchronous, active-high
//    Op           in   6  IR[31:26], valid from DECODE onward
//    PCWrite      out  1  unconditional PC load
//    PCWriteCond  out  1  PC load if ALU Zero (the datapath ANDs this with Zero)
//    IorD         out  1  memory address: 0=PC, 1=ALUOut
//    MemRead      out  1  memory read strobe
//    MemWrite     out  1  memory write strobe
//    MemtoReg     out  1  register write data: 0=ALUOut, 1=MDR
//    IRWrite      out  1  IR load
//    PCSource     out  2  00=ALU result, 01=ALUOut, 10=jump target
//    ALUOp        out  2  00=add, 01=sub, 10=use funct
//    ALUSrcA      out  1  0=PC, 1=A
//    ALUSrcB      out  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
//    RegWrite     out  1  register file write
//    RegDst       out  1  destination register: 0=rt, 1=rd
//    instr_done   out  1  1-cycle pulse in the last cycle of each instruction
//    illegal_op   out  1  1-cycle pulse in DECODE for an unrecognised Op
//    state        out  4  current state code (debug/verification)
// ============================================================================
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  // State codes are visible on the state port, so the values are fixed.
  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADDR  = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_REXEC    = 4'd7,
    S_RWB      = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDIEXEC = 4'd11,
    S_ADDIWB   = 4'd12
  } state_t;

  state_t r_state;
  state_t w_next;

  // The opcode is decoded only in DECODE and MEMADDR, the two states that
  // branch on it.
  logic w_op_mem;
  logic w_op_known;

  assign w_op_mem   = (Op == OP_LW) || (Op == OP_SW);
  assign w_op_known = w_op_mem || (Op == OP_RTYPE) || (Op == OP_BEQ) ||
                      (Op == OP_J) || (Op == OP_ADDI);

  // --------------------------------------------------------------------------
  // State register. The reset is asynchronous, and every output is decoded
  // from r_state. As a result, asserting rst clears all strobes immediately
  // and drops any instruction in flight, with no partial writes.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_RESET:    w_next = S_FETCH;
      S_FETCH:    w_next = S_DECODE;
      S_DECODE: begin
        if (w_op_mem)            w_next = S_MEMADDR;
        else if (Op == OP_RTYPE) w_next = S_REXEC;
        else if (Op == OP_BEQ)   w_next = S_BRANCH;
        else if (Op == OP_J)     w_next = S_JUMP;
        else if (Op == OP_ADDI)  w_next = S_ADDIEXEC;
        else                     w_next = S_FETCH;  // illegal: retire at once
      end
      // Only loads and stores reach MEMADDR. Any opcode other than a store
      // is therefore treated as a load.
      S_MEMADDR:  w_next = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = S_MEMWB;
      S_REXEC:    w_next = S_RWB;
      S_ADDIEXEC: w_next = S_ADDIWB;
      S_MEMWB,
      S_MEMWRITE,
      S_RWB,
      S_BRANCH,
      S_JUMP,
      S_ADDIWB:   w_next = S_FETCH;
      default:    w_next = S_FETCH;  // unused codes 13-15 recover to FETCH
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode. Every output defaults to 0, so RESET and the unused codes
  // drive all-zero outputs without needing their own case items.
  // --------------------------------------------------------------------------
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    case (r_state)
      S_FETCH: begin
        // Read the instruction into IR and, on the same edge, load PC+4
        // (the ALU adds 4 to PC; PCSource=00 selects the ALU result).
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      S_DECODE: begin
        // Compute the branch target ahead of time, so BRANCH can take it
        // straight from ALUOut.
        ALUSrcB = 2'b11;
        if (!w_op_known) begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_MEMADDR,
      S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWRITE: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_REXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDIWB: begin
        // An overflowing result is still written back. The datapath raises
        // the overflow flag itself.
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        // Subtract A-B. The datapath gates PCWriteCond with Zero.
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Self-checking bench for multicycle_control. Each instruction
//                record lists its opcode and its expected state walk. In
//                every cycle the bench compares the state and the whole
//                output bundle with values it derives from the per-state
//                output table. Hand-written sequences cover the multi-cycle
//                corner cases: an opcode change after DECODE and a reset in
//                the middle of an instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  logic       clk;
  logic       rst;
  logic [5:0] Op;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst, instr_done, illegal_op;
  logic [3:0] state;

  int checks;
  int errors;

  multicycle_control dut (
    .clk        (clk),
    .rst        (rst),
    .Op         (Op),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .IRWrite    (IRWrite),
    .PCSource   (PCSource),
    .ALUOp      (ALUOp),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle, packed MSB first:
  // PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite PCSource[2]
  // ALUOp[2] ALUSrcA ALUSrcB[2] RegWrite RegDst instr_done illegal_op
  logic [17:0] act;
  assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst,
                instr_done, illegal_op};

  // Expected outputs for each state, taken from the control table.
  function automatic logic [17:0] exp_outs(input logic [3:0] s, input logic [5:0] op);
    logic pcw, pcwc, iord, mr, mw, m2r, irw, srca, rw, rd, dn, ill;
    logic [1:0] pcs, aop, srcb;
    logic known;
    known = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
            (op == 6'b000100) || (op == 6'b000010) || (op == 6'b001000);
    {pcw, pcwc, iord, mr, mw, m2r, irw, srca, rw, rd, dn, ill} = '0;
    pcs = 2'b00; aop = 2'b00; srcb = 2'b00;
    case (s)
      4'd1:  begin mr = 1; irw = 1; srcb = 2'b01; pcw = 1; end
      4'd2:  begin srcb = 2'b11; ill = !known; dn = !known; end
      4'd3:  begin srca = 1; srcb = 2'b10; end
      4'd4:  begin mr = 1; iord = 1; end
      4'd5:  begin m2r = 1; rw = 1; dn = 1; end
      4'd6:  begin mw = 1; iord = 1; dn = 1; end
      4'd7:  begin srca = 1; aop = 2'b10; end
      4'd8:  begin rd = 1; rw = 1; dn = 1; end
      4'd9:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; dn = 1; end
      4'd10: begin pcw = 1; pcs = 2'b10; dn = 1; end
      4'd11: begin srca = 1; srcb = 2'b10; end
      4'd12: begin rw = 1; dn = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, m2r, irw, pcs, aop, srca, srcb, rw, rd, dn, ill};
  endfunction

  task automatic check(input string name, input logic [3:0] exp_state, input logic [17:0] exp_o);
    checks++;
    if (state !== exp_state || act !== exp_o) begin
      errors++;
      $display("FAIL %s: state=%0d outs=%b, required state=%0d outs=%b",
               name, state, act, exp_state, exp_o);
    end
  endtask

  typedef struct {
    string      name;
    logic [5:0] op;
    int         len;
    logic [19:0] seq;   // expected state codes, one nibble per cycle, MSB first
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"lw",    6'b100011, 5, 20'h12345};
    vecs[1] = '{"rtype", 6'b000000, 4, 20'h12780};
    vecs[2] = '{"sw",    6'b101011, 4, 20'h12360};
    vecs[3] = '{"beq",   6'b000100, 3, 20'h12900};
    vecs[4] = '{"j",     6'b000010, 3, 20'h12A00};
    vecs[5] = '{"addi",  6'b001000, 4, 20'h12BC0};
    vecs[6] = '{"ill3f", 6'b111111, 2, 20'h12000};
    vecs[7] = '{"ill01", 6'b000001, 2, 20'h12000};

    checks = 0;
    errors = 0;
    Op  = 6'b111111;
    rst = 1'b1;

    // Hold reset for 3 cycles.
    repeat (3) @(negedge clk);
    check("reset", 4'd0, 18'd0);
    rst = 1'b0;
    @(negedge clk);
    check("first_fetch", 4'd1, exp_outs(4'd1, Op));

    // Run every record back to back. Each record starts in FETCH.
    for (int v = 0; v < 8; v++) begin
      Op = vecs[v].op;
      for (int k = 0; k < vecs[v].len; k++) begin
        logic [3:0] es;
        logic [19:0] sq;
        sq = vecs[v].seq;
        es = sq[19 - 4*k -: 4];
        check(vecs[v].name, es, exp_outs(es, Op));
        @(negedge clk);
      end
    end
    check("after_table", 4'd1, exp_outs(4'd1, Op));

    // Changing the opcode after DECODE has no effect: the R-type
    // instruction still finishes through RWB.
    Op = 6'b000000;
    @(negedge clk); check("rchg_decode", 4'd2, exp_outs(4'd2, Op));
    @(negedge clk); check("rchg_rexec", 4'd7, exp_outs(4'd7, Op));
    Op = 6'b100011;
    @(negedge clk); check("rchg_rwb", 4'd8, exp_outs(4'd8, Op));
    @(negedge clk); check("rchg_fetch", 4'd1, exp_outs(4'd1, Op));

    // Reset arrives mid-instruction while the load is in MEMREAD.
    Op = 6'b100011;
    @(negedge clk); check("rst_decode", 4'd2, exp_outs(4'd2, Op));
    @(negedge clk); check("rst_memaddr", 4'd3, exp_outs(4'd3, Op));
    @(negedge clk); check("rst_memread", 4'd4, exp_outs(4'd4, Op));
    #1 rst = 1'b1;
    #1 check("rst_async", 4'd0, 18'd0);
    @(negedge clk); check("rst_hold", 4'd0, 18'd0);
    rst = 1'b0;
    @(negedge clk); check("rst_refetch", 4'd1, exp_outs(4'd1, Op));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
